stage_mem_lsu: RTL and testbench
================================

// Module: stage_mem_lsu
// PURPOSE
//  Parametrised MEM stage / load-store unit: replaces the word-only MEM stage.
//  - Byte, half and word loads/stores (RV32 funct3); loads sign- or zero-extend.
//  - Configurable data-memory wait states; the pipeline is stalled until each access completes.
//  - Misaligned or illegal accesses are flagged and suppressed.
//  - Sits between the EX/MEM and MEM/WB pipeline registers.
// PARAMETERS
//  REG_WIDTH        32   data/address width; fixed at 32 for RV32
//  DMEM_ADDR_WIDTH  10   byte-address bits used; upper address bits ignored (index wraps)
//  DMEM_DEPTH       1024 memory size in bytes; must equal 2**DMEM_ADDR_WIDTH
//  MEM_LATENCY      1    wait cycles per access, >=1
// PORTS
//  clk                  in   1   clock
//  reset_n              in   1   asynchronous reset, active low
//  EX_MEM_valid         in   1   EX/MEM holds a live instruction
//  EX_MEM_mem_read_en   in   1   load
//  EX_MEM_mem_write_en  in   1   store
//  EX_MEM_funct3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  EX_MEM_alu_out       in   32  byte address
//  EX_MEM_dataB         in   32  store data; low bytes used for B/H
//  DMEM_data_out        out  32  extended load result, registered
//  MEM_load_valid       out  1   one-cycle pulse: DMEM_data_out updated this cycle
//  MEM_stall            out  1   freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  MEM_fault            out  1   misaligned or illegal access (combinational)
// BEHAVIOUR
//  Reset: state IDLE, counter 0; DMEM_data_out=0; MEM_load_valid=0; MEM_stall=0.
//   Memory contents are not cleared.
//  req   = EX_MEM_valid & (rd_en | wr_en).
//  fault = req & (funct3 in {011,110,111} | H/HU/SH with addr[0] | W/SW with addr[1:0]!=0).
//  Both rd_en and wr_en set: treated as a store; the read is ignored.
//  FSM IDLE/WAIT/DONE:
//   - IDLE, req & !fault: MEM_stall=1; cnt<=MEM_LATENCY-1.
//     Next state: DONE if MEM_LATENCY==1, else WAIT.
//   - WAIT: MEM_stall=1; cnt decrements; go to DONE after the cycle with cnt==1.
//   - Edge into DONE: the store commits to the addressed byte lanes only,
//     or the load result is captured into DMEM_data_out.
//   - DONE: MEM_stall=0; MEM_load_valid=1 if load; always returns to IDLE.
//     EX/MEM advances on this edge; DONE never re-accepts the request it just finished.
//  Total stall = MEM_LATENCY cycles; the result is visible in the DONE cycle.
//  Fault: no memory access, no stall, no state change; DMEM_data_out holds its value;
//   MEM_fault is high while the request is present.
//  !EX_MEM_valid: inputs ignored in IDLE.
//  Inputs are held stable by the stall during WAIT.
//  Load extension:
//   - B: byte at addr[1:0], sign-extended; BU zero-extends.
//   - H: half at addr[1], sign-extended; HU zero-extends.
//   - W: full word.
//  Little-endian byte order.
//  reset_n low mid-access: immediate return to IDLE; the pending store is dropped,
//   memory is unaltered, stall releases asynchronously.
// STRUCTURE
//  risc_v_defines.vh:
//   - funct3 encodings F3_LB/LH/LW/LBU/LHU/SB/SH/SW;
//   - LSU state encodings;
//   - MEM_LATENCY default.
//  Sub-module dmem_byte_en: byte-lane RAM, 4 x 8-bit banks.
//   - Inputs: wr_be[3:0], word index = addr[DMEM_ADDR_WIDTH-1:2].
//   - Synchronous write, combinational read.
//  Top holds the FSM/counter, lane steering, byte-enable generation, extension and the output register.
// TESTING
//  1 SW 0xDEADBEEF @0x10, LATENCY=1:
//    MEM_stall high 1 cycle; then LW @0x10 -> DMEM_data_out=0xDEADBEEF, MEM_load_valid pulse.
//  2 SB 0x7F @0x11, SH 0x8001 @0x12 over (1) word:
//    LW @0x10 -> 0x80017FEF; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080;
//    LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
//  3 MEM_LATENCY=3, LW:
//    MEM_stall high exactly 3 cycles; data and MEM_load_valid in the 4th cycle; EX/MEM advances once.
//  4 LW @0x12, SH @0x13, funct3=011:
//    MEM_fault=1, MEM_stall=0, memory and DMEM_data_out unchanged.
//  5 SW 0x12345678 @0x20 with reset_n pulsed low during WAIT (LATENCY=3):
//    outputs 0, state IDLE; later LW @0x20 returns prior contents.
//  6 Back-to-back SW @0x04 then LW @0x04, EX_MEM_valid=0 bubble between:
//    correct data; no access issued for the bubble; address 0x404 aliases 0x004.

Source files
------------

// File: rtl/stage_mem_lsu_pkg.sv
// Shared encodings and lane-steering helpers for the MEM-stage load/store unit.
package stage_mem_lsu_pkg;

    // RV32 funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned MEM_LATENCY_DEFAULT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } lsu_state_e;

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extend(logic [2:0] f3, logic [31:0] word,
                                                logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   load_extend = {{24{b[7]}}, b};
            F3_LBU:  load_extend = {24'h0, b};
            F3_LH:   load_extend = {{16{h[15]}}, h};
            F3_LHU:  load_extend = {16'h0, h};
            default: load_extend = word;
        endcase
    endfunction

    // Byte enables for a store of the given size (funct3[1:0]) at byte offset off.
    function automatic logic [3:0] store_be(logic [1:0] size, logic [1:0] off);
        case (size)
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the low bytes of the store data so every enabled lane sees them.
    function automatic logic [31:0] store_data(logic [1:0] size, logic [31:0] data);
        case (size)
            2'b00:   store_data = {4{data[7:0]}};
            2'b01:   store_data = {2{data[15:0]}};
            default: store_data = data;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_lsu_dmem_byte_en.sv
// Byte-lane data RAM: four 8-bit banks, synchronous per-lane write, combinational read.
module dmem_byte_en #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            wr_be_i,
    input  logic [ADDR_WIDTH-3:0] word_idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Words = DEPTH / 4;

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] bank_q [Words];

        // Write only the lanes enabled for this store; contents are never cleared.
        always_ff @(posedge clk_i) begin
            if (we_i && wr_be_i[lane]) begin
                bank_q[word_idx_i] <= wdata_i[8*lane +: 8];
            end
        end

        assign rdata_o[8*lane +: 8] = bank_q[word_idx_i];
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: byte/half/word access with configurable wait states.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned REG_WIDTH       = 32,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned DMEM_DEPTH      = 1024,
    parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 EX_MEM_valid,
    input  logic                 EX_MEM_mem_read_en,
    input  logic                 EX_MEM_mem_write_en,
    input  logic [2:0]           EX_MEM_funct3,
    input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
    output logic [REG_WIDTH-1:0] DMEM_data_out,
    output logic                 MEM_load_valid,
    output logic                 MEM_stall,
    output logic                 MEM_fault
);

    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    lsu_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic load_q, load_d;
    logic [REG_WIDTH-1:0] data_q;

    logic       req, is_store, is_load, fault, misaligned, illegal_f3;
    logic       stall, commit, mem_we;
    logic [1:0] size, off;
    logic [3:0] wr_be;
    logic [31:0] wdata, rdata, load_ext;
    logic       unused_addr;

    assign size = EX_MEM_funct3[1:0];
    assign off  = EX_MEM_alu_out[1:0];

    // A store wins when both enables are set; the read is dropped.
    assign is_store = EX_MEM_mem_write_en;
    assign is_load  = EX_MEM_mem_read_en & ~EX_MEM_mem_write_en;
    assign req      = EX_MEM_valid & (EX_MEM_mem_read_en | EX_MEM_mem_write_en);

    assign illegal_f3 = (EX_MEM_funct3 == 3'b011) || (EX_MEM_funct3 == 3'b110) ||
                        (EX_MEM_funct3 == 3'b111);

    // Alignment check by access size; illegal funct3 is caught separately.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign fault = req & (illegal_f3 | misaligned);

    // Next-state, counter and stall; commit marks the edge into StDone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        stall   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !fault) begin
                    stall  = 1'b1;
                    cnt_d  = CntW'(MEM_LATENCY - 1);
                    load_d = is_load;
                    if (MEM_LATENCY == 1) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    commit  = 1'b1;
                end
            end
            StDone: begin
                // EX/MEM advances on this edge, so the finished request is not re-accepted.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, counter, load flag and registered load result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            if (commit && is_load) begin
                data_q <= load_ext;
            end
        end
    end

    assign wr_be  = store_be(size, off);
    assign wdata  = store_data(size, EX_MEM_dataB);
    // Reset gates the write so an aborted store never reaches memory.
    assign mem_we = commit & is_store & reset_n;

    dmem_byte_en #(
        .ADDR_WIDTH (DMEM_ADDR_WIDTH),
        .DEPTH      (DMEM_DEPTH)
    ) u_dmem (
        .clk_i      (clk),
        .we_i       (mem_we),
        .wr_be_i    (wr_be),
        .word_idx_i (EX_MEM_alu_out[DMEM_ADDR_WIDTH-1:2]),
        .wdata_i    (wdata),
        .rdata_o    (rdata)
    );

    assign load_ext = load_extend(EX_MEM_funct3, rdata, off);

    // Address bits above the memory size wrap and are intentionally ignored.
    assign unused_addr = ^EX_MEM_alu_out[REG_WIDTH-1:DMEM_ADDR_WIDTH];

    assign DMEM_data_out  = data_q;
    assign MEM_load_valid = (state_q == StDone) & load_q;
    // Stall drops as soon as reset asserts, even with a request still present.
    assign MEM_stall      = stall & reset_n;
    assign MEM_fault      = fault;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: one instance at latency 1, one at latency 3, shared inputs.
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid1, valid3;
    logic        rd_en, wr_en;
    logic [2:0]  f3;
    logic [31:0] addr, wdat;

    logic [31:0] dout1, dout3;
    logic        lv1, lv3, stall1, stall3, flt1, flt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stage_mem_lsu #(.MEM_LATENCY(1)) u_dut1 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .EX_MEM_valid        (valid1),
        .EX_MEM_mem_read_en  (rd_en),
        .EX_MEM_mem_write_en (wr_en),
        .EX_MEM_funct3       (f3),
        .EX_MEM_alu_out      (addr),
        .EX_MEM_dataB        (wdat),
        .DMEM_data_out       (dout1),
        .MEM_load_valid      (lv1),
        .MEM_stall           (stall1),
        .MEM_fault           (flt1)
    );

    stage_mem_lsu #(.MEM_LATENCY(3)) u_dut3 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .EX_MEM_valid        (valid3),
        .EX_MEM_mem_read_en  (rd_en),
        .EX_MEM_mem_write_en (wr_en),
        .EX_MEM_funct3       (f3),
        .EX_MEM_alu_out      (addr),
        .EX_MEM_dataB        (wdat),
        .DMEM_data_out       (dout3),
        .MEM_load_valid      (lv3),
        .MEM_stall           (stall3),
        .MEM_fault           (flt3)
    );

    typedef struct {
        bit          lat3;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          stalls;
        bit          lv;
        bit          flt;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit lat3, bit rd, bit wr, logic [2:0] fn, logic [31:0] a,
                                logic [31:0] wd, int stalls, bit lv, bit flt,
                                logic [31:0] dout);
        vec_t v;
        v.lat3 = lat3; v.rd = rd; v.wr = wr; v.f3 = fn; v.addr = a; v.wd = wd;
        v.stalls = stalls; v.lv = lv; v.flt = flt; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present one request, count stall cycles, sample the first non-stalled cycle.
    task automatic run_access(input bit lat3, input bit rd, input bit wr, input logic [2:0] fn,
                              input logic [31:0] a, input logic [31:0] wd,
                              output int stalls, output bit lv, output bit flt,
                              output logic [31:0] dout, output bit timeout);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; f3 = fn; addr = a; wdat = wd;
        valid1 = !lat3; valid3 = lat3;
        stalls = 0; timeout = 1'b1; lv = 1'b0; flt = 1'b0; dout = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lat3 ? stall3 : stall1) begin
                stalls++;
            end else begin
                lv      = lat3 ? lv3 : lv1;
                flt     = lat3 ? flt3 : flt1;
                dout    = lat3 ? dout3 : dout1;
                timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        valid1 = 1'b0; valid3 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          st;
        bit          lv, flt, to;
        logic [31:0] d;

        reset_n = 1'b0;
        valid1 = 1'b0; valid3 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        f3 = 3'b000; addr = '0; wdat = '0;

        // Directed vectors; dout is the value held after each access.
        vecs.push_back(mk(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, 3'b000, 32'h11, 32'hAAAAAA7F, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, 3'b001, 32'h12, 32'h55558001, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 0, 32'h80017FEF));
        vecs.push_back(mk(0, 1, 0, 3'b000, 32'h13, 32'h0,        1, 1, 0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 1, 0, 3'b100, 32'h13, 32'h0,        1, 1, 0, 32'h00000080));
        vecs.push_back(mk(0, 1, 0, 3'b001, 32'h12, 32'h0,        1, 1, 0, 32'hFFFF8001));
        vecs.push_back(mk(0, 1, 0, 3'b101, 32'h12, 32'h0,        1, 1, 0, 32'h00008001));
        vecs.push_back(mk(0, 1, 0, 3'b000, 32'h11, 32'h0,        1, 1, 0, 32'h0000007F));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h12, 32'h0,        0, 0, 1, 32'h0000007F));
        vecs.push_back(mk(0, 0, 1, 3'b001, 32'h13, 32'h0000FFFF, 0, 0, 1, 32'h0000007F));
        vecs.push_back(mk(0, 1, 0, 3'b011, 32'h10, 32'h0,        0, 0, 1, 32'h0000007F));
        vecs.push_back(mk(0, 0, 1, 3'b010, 32'h11, 32'h01020304, 0, 0, 1, 32'h0000007F));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 0, 32'h80017FEF));
        vecs.push_back(mk(0, 1, 1, 3'b010, 32'h18, 32'h0BADCAFE, 1, 0, 0, 32'h80017FEF));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h18, 32'h0,        1, 1, 0, 32'h0BADCAFE));
        vecs.push_back(mk(1, 0, 1, 3'b010, 32'h40, 32'hA5A50F0F, 3, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 3'b010, 32'h40, 32'h0,        3, 1, 0, 32'hA5A50F0F));
        vecs.push_back(mk(1, 1, 0, 3'b101, 32'h42, 32'h0,        3, 1, 0, 32'h0000A5A5));
        vecs.push_back(mk(1, 1, 0, 3'b000, 32'h40, 32'h0,        3, 1, 0, 32'h0000000F));
        vecs.push_back(mk(1, 1, 0, 3'b001, 32'h41, 32'h0,        0, 0, 1, 32'h0000000F));

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset stall1", 32'(stall1), 32'h0);
        check("reset lv1",    32'(lv1),    32'h0);
        check("reset dout1",  dout1,       32'h0);
        check("reset stall3", 32'(stall3), 32'h0);
        check("reset dout3",  dout3,       32'h0);

        foreach (vecs[i]) begin
            run_access(vecs[i].lat3, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                       vecs[i].wd, st, lv, flt, d, to);
            check($sformatf("v%0d timeout", i), 32'(to),  32'h0);
            check($sformatf("v%0d stalls", i),  32'(st),  32'(vecs[i].stalls));
            check($sformatf("v%0d lv", i),      32'(lv),  32'(vecs[i].lv));
            check($sformatf("v%0d fault", i),   32'(flt), 32'(vecs[i].flt));
            check($sformatf("v%0d dout", i),    d,        vecs[i].dout);
        end

        // Latency 3: load pulse lasts one cycle and the request is not re-issued.
        run_access(1, 1, 0, 3'b010, 32'h40, 32'h0, st, lv, flt, d, to);
        check("lat3 reload stalls", 32'(st), 32'd3);
        @(negedge clk);
        check("lat3 after-done lv",    32'(lv3),    32'h0);
        check("lat3 after-done stall", 32'(stall3), 32'h0);

        // Store, bubble carrying a would-be store, then an aliased load.
        run_access(0, 0, 1, 3'b010, 32'h04, 32'h11223344, st, lv, flt, d, to);
        check("b2b sw stalls", 32'(st), 32'd1);
        @(posedge clk); #1;
        valid1 = 1'b0; wr_en = 1'b1; f3 = 3'b010; addr = 32'h04; wdat = 32'hFFFFFFFF;
        @(negedge clk);
        check("bubble stall", 32'(stall1), 32'h0);
        check("bubble lv",    32'(lv1),    32'h0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        run_access(0, 1, 0, 3'b010, 32'h404, 32'h0, st, lv, flt, d, to);
        check("alias lw dout", d, 32'h11223344);
        check("alias lw lv",   32'(lv), 32'h1);

        // Reset in the middle of a latency-3 store must drop it.
        run_access(1, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, st, lv, flt, d, to);
        check("pre-abort sw stalls", 32'(st), 32'd3);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b1; f3 = 3'b010; addr = 32'h20; wdat = 32'h12345678;
        valid3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort wait stall", 32'(stall3), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort stall", 32'(stall3), 32'h0);
        check("abort lv",    32'(lv3),    32'h0);
        check("abort dout",  dout3,       32'h0);
        @(posedge clk); #1;
        valid3 = 1'b0; wr_en = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post-abort idle stall", 32'(stall3), 32'h0);
        run_access(1, 1, 0, 3'b010, 32'h20, 32'h0, st, lv, flt, d, to);
        check("post-abort lw stalls", 32'(st), 32'd3);
        check("post-abort lw dout",   d,       32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
